// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU data-memory access unit:
// size encodings, FSM states, byte/half lane offsets and the store-merge helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RMW_READ = 2'b01,
    WRITE    = 2'b10
  } state_e;

  localparam logic [1:0] LANE_B0   = 2'd0;
  localparam logic [1:0] LANE_B1   = 2'd1;
  localparam logic [1:0] LANE_B2   = 2'd2;
  localparam logic [1:0] LANE_B3   = 2'd3;
  localparam logic [1:0] LANE_H_LO = 2'd0;
  localparam logic [1:0] LANE_H_HI = 2'd2;

  // Replace the addressed lane(s) of an existing word with right-justified store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input size_e       size);
    logic [31:0] m;
    m = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          LANE_B0: m[7:0]   = wdata[7:0];
          LANE_B1: m[15:8]  = wdata[7:0];
          LANE_B2: m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset == LANE_H_LO) m[15:0] = wdata[15:0];
        else                     m[31:16] = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects the addressed byte/half lane of a
// memory word and zero- or sign-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    case (offset)
      LANE_B0: b = word[7:0];
      LANE_B1: b = word[15:8];
      LANE_B2: b = word[23:16];
      LANE_B3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = (offset == LANE_H_HI) ? word[31:16] : word[15:0];

    result = '0;
    case (size)
      SIZE_BYTE: result = {{24{is_signed & b[7]}}, b};
      SIZE_HALF: result = {{16{is_signed & h[15]}}, h};
      SIZE_WORD: result = word;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and a word-wide data memory: single-cycle
// loads, word stores direct, sub-word stores via read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  state_e      state, state_nxt;
  size_e       req_size_e;
  size_e       size_q;
  logic        accept;
  logic        req_err;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] load_data;

  assign req_size_e = size_e'(req_size);
  assign busy       = (state != IDLE);
  assign accept     = req_valid && !busy && !reset;

  always_comb begin
    req_err = 1'b0;
    case (req_size_e)
      SIZE_HALF: req_err = req_addr[0];
      SIZE_WORD: req_err = |req_addr[1:0];
      SIZE_ILL:  req_err = 1'b1;
      default:   req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_err = 1'b1;
  end

  load_align u_load_align (
    .word      (mem_rdata),
    .offset    (req_addr[1:0]),
    .size      (req_size_e),
    .is_signed (req_signed),
    .result    (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // mem_we is gated by reset so a reset landing in WRITE kills the negedge write.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = {2'b00, addr_q};
    mem_wdata = merged_q;
    case (state)
      IDLE: begin
        mem_addr = {2'b00, req_addr[31:2]};
        if (accept && req_we && !req_err)
          state_nxt = (req_size_e == SIZE_WORD) ? WRITE : RMW_READ;
      end
      RMW_READ: state_nxt = WRITE;
      WRITE: begin
        mem_we    = !reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      err_valid  <= 1'b0;
      resp_rdata <= '0;
      err_addr   <= '0;
    end else begin
      resp_valid <= accept && !req_we && !req_err;
      err_valid  <= accept && req_err;
      if (accept && req_err)            err_addr   <= req_addr;
      if (accept && !req_we && !req_err) resp_rdata <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      addr_q   <= req_addr[31:2];
      off_q    <= req_addr[1:0];
      size_q   <= req_size_e;
      wdata_q  <= req_wdata[15:0];
      merged_q <= req_wdata;
    end else if (state == RMW_READ) begin
      merged_q <= merge_store(mem_rdata, {16'h0000, wdata_q}, off_q, size_q);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 64-word behavioural
// memory (combinational read, negedge write).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, err_valid, mem_we;
  logic [31:0] resp_rdata, err_addr, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:63];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .err_valid  (err_valid),
    .err_addr   (err_addr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:0]];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hA0A0A0A0;
    mem[1] = 32'h00000000;
    mem[2] = 32'h00000001;
    mem[3] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (mem_we) mem[mem_addr[5:0]] = mem_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick; tick;
    chk("rst_busy",       busy,       0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err_valid",  err_valid,  0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_err_addr",   err_addr,   0);
    chk("rst_mem_we",     mem_we,     0);

    // store presented while reset is high must be dropped
    drive(1, 1, 2'b10, 0, 32'h0, 32'h55555555);
    tick;
    chk("rst_req_busy",   busy,   0);
    chk("rst_req_mem_we", mem_we, 0);
    reset = 1'b0;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    chk("rst_req_mem0", mem[0], 32'hA0A0A0A0);

    // word load at 0x08
    drive(1, 0, 2'b10, 0, 32'h08, 32'h0);
    chk("ld_busy_accept", busy, 0);
    chk("ld_mem_addr",    mem_addr, 32'h2);
    tick;
    chk("ld_resp_valid", resp_valid, 1);
    chk("ld_resp_rdata", resp_rdata, 32'h00000001);
    chk("ld_busy_after", busy, 0);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    chk("ld_resp_drop", resp_valid, 0);

    // byte store 0xAB at 0x05
    drive(1, 1, 2'b00, 0, 32'h05, 32'h000000AB);
    chk("sb_busy_accept", busy, 0);
    tick;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("sb_rmw_busy",  busy,     1);
    chk("sb_rmw_we",    mem_we,   0);
    chk("sb_rmw_addr",  mem_addr, 32'h1);
    tick;
    chk("sb_wr_busy",   busy,      1);
    chk("sb_wr_we",     mem_we,    1);
    chk("sb_wr_wdata",  mem_wdata, 32'h0000AB00);
    chk("sb_wr_resp",   resp_valid, 0);
    tick;
    chk("sb_done_busy", busy,   0);
    chk("sb_done_we",   mem_we, 0);
    chk("sb_mem1",      mem[1], 32'h0000AB00);
    chk("sb_no_resp",   resp_valid, 0);

    // sub-word loads, back to back
    drive(1, 0, 2'b00, 1, 32'h05, 32'h0);
    tick;
    chk("lb_signed", resp_rdata, 32'hFFFFFFAB);
    drive(1, 0, 2'b00, 0, 32'h05, 32'h0);
    tick;
    chk("lb_unsigned", resp_rdata, 32'h000000AB);
    drive(1, 0, 2'b01, 0, 32'h04, 32'h0);
    tick;
    chk("lh_unsigned", resp_rdata, 32'h0000AB00);
    drive(1, 0, 2'b01, 1, 32'h0E, 32'h0);
    tick;
    chk("lh_signed_hi", resp_rdata, 32'hFFFFDEAD);
    drive(1, 0, 2'b00, 0, 32'h0F, 32'h0);
    tick;
    chk("lb_lane3", resp_rdata, 32'h000000DE);
    drive(1, 0, 2'b00, 1, 32'h0C, 32'h0);
    tick;
    chk("lb_lane0_signed", resp_rdata, 32'hFFFFFFEF);
    chk("lb_valid", resp_valid, 1);
    drive(1, 0, 2'b10, 1, 32'h0C, 32'h0);
    tick;
    chk("lw_ignores_signed", resp_rdata, 32'hDEADBEEF);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;

    // half store into upper lane
    drive(1, 1, 2'b01, 0, 32'h0E, 32'h0000CAFE);
    tick;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    chk("sh_wr_wdata", mem_wdata, 32'hCAFEBEEF);
    tick;
    chk("sh_mem3", mem[3], 32'hCAFEBEEF);

    // word store goes straight to WRITE
    drive(1, 1, 2'b10, 0, 32'h00, 32'h12345678);
    tick;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("sw_busy",  busy,      1);
    chk("sw_we",    mem_we,    1);
    chk("sw_wdata", mem_wdata, 32'h12345678);
    tick;
    chk("sw_done_busy", busy, 0);
    chk("sw_mem0", mem[0], 32'h12345678);

    // error cases
    drive(1, 1, 2'b01, 0, 32'h03, 32'h00005555);
    tick;
    chk("err_half_valid", err_valid, 1);
    chk("err_half_addr",  err_addr,  32'h03);
    chk("err_half_busy",  busy,      0);
    chk("err_half_we",    mem_we,    0);
    chk("err_half_resp",  resp_valid, 0);
    drive(1, 0, 2'b10, 0, 32'h100, 32'h0);
    tick;
    chk("err_range_valid", err_valid, 1);
    chk("err_range_addr",  err_addr,  32'h100);
    chk("err_range_resp",  resp_valid, 0);
    chk("err_range_we",    mem_we,    0);
    drive(1, 0, 2'b11, 0, 32'h00, 32'h0);
    tick;
    chk("err_size_valid", err_valid, 1);
    chk("err_size_addr",  err_addr,  32'h00);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    chk("err_pulse_end", err_valid, 0);
    chk("err_mem0_kept", mem[0], 32'h12345678);

    // reset during WRITE aborts the half store
    drive(1, 1, 2'b01, 0, 32'h0A, 32'h00001234);
    tick;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("abort_rmw_busy", busy, 1);
    tick;
    chk("abort_wr_we_pre", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("abort_wr_we_gated", mem_we, 0);
    tick;
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    tick;
    chk("abort_mem2", mem[2], 32'h00000001);

    // back-to-back word loads
    drive(1, 0, 2'b10, 0, 32'h00, 32'h0);
    tick;
    chk("b2b0_valid", resp_valid, 1);
    chk("b2b0_data",  resp_rdata, 32'h12345678);
    drive(1, 0, 2'b10, 0, 32'h04, 32'h0);
    tick;
    chk("b2b1_valid", resp_valid, 1);
    chk("b2b1_data",  resp_rdata, 32'h0000AB00);
    drive(1, 0, 2'b10, 0, 32'h08, 32'h0);
    tick;
    chk("b2b2_valid", resp_valid, 1);
    chk("b2b2_data",  resp_rdata, 32'h00000001);
    chk("b2b2_busy",  busy, 0);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    chk("b2b_end", resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
